// File: rtl/pcie_x1_sync_rx_if.sv
// Handshake and word bus between a foreign-domain source, this receiver and a downstream consumer.
//   req_in   : source request (asynchronous to s_clk)
//   data_in  : source word, stable while req_in is high and until ack_out is seen
//   ack_out  : acknowledge returned to the source
//   dout     : captured word
//   dout_vld : dout valid
//   dout_rdy : downstream ready
// slave  : receiver side (the pcie_x1_sync_rx block)
// master : source/consumer side
interface pcie_x1_sync_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_in;
  logic [WIDTH-1:0] data_in;
  logic             ack_out;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;

  modport slave (
    input  req_in,
    input  data_in,
    output ack_out,
    output dout,
    output dout_vld,
    input  dout_rdy
  );

  modport master (
    output req_in,
    output data_in,
    input  ack_out,
    input  dout,
    input  dout_vld,
    output dout_rdy
  );
endinterface

// File: rtl/pcie_x1_sync_rx.sv
// Destination end of a four-phase req/ack crossing: synchronises req_in into s_clk,
// captures data_in, offers it on a valid/ready port, then acknowledges the source.
// Ports:
//   s_clk    : block clock
//   rst      : synchronous active-high reset
//   rx       : pcie_x1_sync_rx_if.slave (req_in, data_in, ack_out, dout, dout_vld, dout_rdy)
//   busy     : high whenever the FSM is not idle (decoded from state)
//   xfer_cnt : completed-transfer counter, wraps silently
//   to_err   : sticky ACK_HI timeout error
// Build option: define PCIE_X1_SYNC_RX_TIMEOUT_EN to enable the ACK_HI timeout counter;
// otherwise to_err is tied low. Port list is identical in both builds.
module pcie_x1_sync_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TO_CYCLES   = 1024
) (
  input  logic                   s_clk,
  input  logic                   rst,
  pcie_x1_sync_rx_if.slave       rx,
  output logic                   busy,
  output logic [15:0]            xfer_cnt,
  output logic                   to_err
);

  localparam int unsigned CNT_W = 16;

  // Elaboration-time parameter range check
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_bad_param
    $error("pcie_x1_sync_rx: SYNC_STAGES must be 2..4 and TO_CYCLES 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_OFFER   = 2'd2,
    ST_ACK_HI  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic                   vld_q, vld_d;
  logic [WIDTH-1:0]       dout_q, dout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_s;

  // req_in synchroniser; the last stage is the only consumer-visible request
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx.req_in};
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    vld_d   = vld_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_s) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        dout_d  = rx.data_in;
        vld_d   = 1'b1;
        state_d = ST_OFFER;
      end
      ST_OFFER: begin
        // A req_s drop here is a source protocol violation; finish the transfer anyway
        if (rx.dout_rdy) begin
          vld_d   = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ACK_HI;
        end
      end
      ST_ACK_HI: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge s_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      ack_q   <= 1'b0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PCIE_X1_SYNC_RX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_CYCLES);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             to_err_q, to_err_d;

  // Cycles spent in ACK_HI with the request still up; saturates at the limit
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    if (state_q == ST_OFFER && state_d == ST_ACK_HI) begin
      to_cnt_d = '0;
    end else if (state_q == ST_ACK_HI && req_s && to_cnt_q != TO_LIM) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end
    if (state_q == ST_ACK_HI && to_cnt_d == TO_LIM) to_err_d = 1'b1;
  end

  always_ff @(posedge s_clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign to_err = to_err_q;
`else
  assign to_err = 1'b0;
`endif

  assign rx.ack_out  = ack_q;
  assign rx.dout_vld = vld_q;
  assign rx.dout     = dout_q;
  assign xfer_cnt    = cnt_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcie_x1_sync_rx.sv
// Directed bench for pcie_x1_sync_rx (WIDTH=8, SYNC_STAGES=2, TO_CYCLES=16).
module tb_pcie_x1_sync_rx;

  logic        s_clk;
  logic        rst;
  logic        busy;
  logic [15:0] xfer_cnt;
  logic        to_err;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [7:0]  beats[$];

  pcie_x1_sync_rx_if #(.WIDTH(8)) rx ();

  pcie_x1_sync_rx #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .TO_CYCLES  (16)
  ) dut (
    .s_clk   (s_clk),
    .rst     (rst),
    .rx      (rx.slave),
    .busy    (busy),
    .xfer_cnt(xfer_cnt),
    .to_err  (to_err)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  // Record every accepted output beat (valid and ready seen before the edge)
  always @(posedge s_clk) begin
    if (!rst && rx.dout_vld && rx.dout_rdy) beats.push_back(rx.dout);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge s_clk);
    #1;
  endtask

  task automatic wait_ack(input logic exp, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (rx.ack_out === exp) break;
      tick(1);
    end
    check_eq(tag, 32'(rx.ack_out), 32'(exp));
  endtask

  task automatic xfer(input logic [7:0] d);
    rx.data_in = d;
    rx.req_in  = 1'b1;
    wait_ack(1'b1, 30, "xfer_ack_hi");
    rx.req_in  = 1'b0;
    wait_ack(1'b0, 30, "xfer_ack_lo");
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    rx.req_in   = 1'b0;
    rx.data_in  = 8'h00;
    rx.dout_rdy = 1'b1;
    tick(2);
    rst = 1'b0;

    // Reset state
    check_eq("rst_dout", 32'(rx.dout), 32'h0);
    check_eq("rst_vld", 32'(rx.dout_vld), 32'h0);
    check_eq("rst_ack", 32'(rx.ack_out), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_cnt", 32'(xfer_cnt), 32'h0);
    check_eq("rst_to_err", 32'(to_err), 32'h0);

    // Basic latency with dout_rdy=1
    rx.data_in = 8'hA5;
    rx.req_in  = 1'b1;
    tick(3);
    check_eq("lat_busy_e3", 32'(busy), 32'h1);
    check_eq("lat_vld_e3", 32'(rx.dout_vld), 32'h0);
    tick(1);
    check_eq("lat_dout_e4", 32'(rx.dout), 32'hA5);
    check_eq("lat_vld_e4", 32'(rx.dout_vld), 32'h1);
    tick(1);
    check_eq("lat_ack_e5", 32'(rx.ack_out), 32'h1);
    check_eq("lat_vld_e5", 32'(rx.dout_vld), 32'h0);
    check_eq("lat_cnt_e5", 32'(xfer_cnt), 32'h1);
    rx.req_in = 1'b0;
    tick(2);
    check_eq("ret_ack_e2", 32'(rx.ack_out), 32'h1);
    tick(1);
    check_eq("ret_ack_e3", 32'(rx.ack_out), 32'h0);
    check_eq("ret_busy_e3", 32'(busy), 32'h0);

    // Backpressure: data_in changes while waiting must not disturb dout
    rx.dout_rdy = 1'b0;
    rx.data_in  = 8'hA5;
    rx.req_in   = 1'b1;
    tick(4);
    check_eq("bp_vld_rise", 32'(rx.dout_vld), 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) rx.data_in = 8'h3C;
      tick(1);
      check_eq("bp_dout_hold", 32'(rx.dout), 32'hA5);
      check_eq("bp_vld_hold", 32'(rx.dout_vld), 32'h1);
      check_eq("bp_ack_low", 32'(rx.ack_out), 32'h0);
    end
    rx.dout_rdy = 1'b1;
    tick(1);
    check_eq("bp_ack_after_rdy", 32'(rx.ack_out), 32'h1);
    check_eq("bp_vld_after_rdy", 32'(rx.dout_vld), 32'h0);
    check_eq("bp_cnt", 32'(xfer_cnt), 32'h2);
    rx.req_in = 1'b0;
    tick(3);
    check_eq("bp_ack_drop", 32'(rx.ack_out), 32'h0);

    // Back-to-back four-phase transfers
    beats.delete();
    for (int i = 1; i <= 4; i++) xfer(8'(i));
    check_eq("b2b_beats", 32'(beats.size()), 32'd4);
    if (beats.size() == 4) begin
      for (int i = 0; i < 4; i++) check_eq("b2b_order", 32'(beats[i]), 32'(i + 1));
    end
    check_eq("b2b_cnt", 32'(xfer_cnt), 32'd6);

    // Counter wrap from 0xFFFF
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    check_eq("wrap_preload", 32'(xfer_cnt), 32'hFFFF);
    xfer(8'h77);
    check_eq("wrap_cnt", 32'(xfer_cnt), 32'h0);
    check_eq("wrap_dout", 32'(rx.dout), 32'h77);

    // Reset while in OFFER with req_in held high
    rx.dout_rdy = 1'b0;
    rx.data_in  = 8'hC3;
    rx.req_in   = 1'b1;
    tick(4);
    check_eq("mid_vld_offer", 32'(rx.dout_vld), 32'h1);
    rst = 1'b1;
    tick(1);
    check_eq("mid_rst_dout", 32'(rx.dout), 32'h0);
    check_eq("mid_rst_vld", 32'(rx.dout_vld), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_cnt", 32'(xfer_cnt), 32'h0);
    rst         = 1'b0;
    rx.data_in  = 8'h99;
    rx.dout_rdy = 1'b1;
    wait_ack(1'b1, 30, "post_rst_ack_hi");
    check_eq("post_rst_dout", 32'(rx.dout), 32'h99);
    check_eq("post_rst_cnt", 32'(xfer_cnt), 32'h1);
    rx.req_in = 1'b0;
    wait_ack(1'b0, 30, "post_rst_ack_lo");

    // Request held high in ACK_HI: timeout after 16 cycles when compiled in
    rx.data_in = 8'h11;
    rx.req_in  = 1'b1;
    wait_ack(1'b1, 30, "to_ack_hi");
    tick(15);
    check_eq("to_err_15", 32'(to_err), 32'h0);
    tick(1);
`ifdef PCIE_X1_SYNC_RX_TIMEOUT_EN
    check_eq("to_err_16", 32'(to_err), 32'h1);
`else
    check_eq("to_err_16", 32'(to_err), 32'h0);
`endif
    check_eq("to_ack_held", 32'(rx.ack_out), 32'h1);
    rx.req_in = 1'b0;
    wait_ack(1'b0, 30, "to_ack_lo");
`ifdef PCIE_X1_SYNC_RX_TIMEOUT_EN
    check_eq("to_err_sticky", 32'(to_err), 32'h1);
`else
    check_eq("to_err_sticky", 32'(to_err), 32'h0);
`endif
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("to_err_cleared", 32'(to_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
